// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Checksum stage is enabled with PROGRAM_LOADER_CHECKSUM_EN.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        CHK,
        DONE,
        ERROR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Module name: byte_packer.
module byte_packer
    import program_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] sh;
    logic [1:0]  idx;

    // The 4th byte completes the word straight from the input.
    assign word_valid = en && (idx == 2'(BYTES_PER_WORD - 1));
    assign word       = {data, sh};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh  <= '0;
            idx <= '0;
        end else if (clear) begin
            sh  <= '0;
            idx <= '0;
        end else if (en) begin
            sh  <= {data, sh[23:8]};
            idx <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: byte stream -> instruction memory, holds CPU in reset.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    state_t      state;
    state_t      tail;
    logic [15:0] nwords;
    logic [15:0] wcnt;
    logic [15:0] hdr;
    logic [7:0]  nlo;
    logic [7:0]  sum;
    logic        hcnt;
    logic        acc;
    logic        clear;
    logic        word_valid;
    logic [31:0] word;

    assign acc   = in_valid && in_ready;
    assign clear = start && (state == IDLE || state == DONE || state == ERROR);
    assign hdr   = {in_data, nlo};
    assign tail  = CHK_EN ? CHK : DONE;

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .en         (acc && state == LOAD),
        .data       (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            nwords     <= '0;
            wcnt       <= '0;
            nlo        <= '0;
            sum        <= '0;
            hcnt       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                IDLE, ERROR: ;
                DONE: begin
                    cpu_reset <= 1'b0;
                    load_done <= 1'b1;
                end
                HDR: if (acc) begin
                    sum  <= sum + in_data;
                    nlo  <= in_data;
                    hcnt <= ~hcnt;
                    if (hcnt == 1'(HDR_BYTES - 1)) begin
                        nwords <= hdr;
                        if (hdr == 16'd0) begin
                            state    <= tail;
                            in_ready <= CHK_EN;
                        end else if (hdr > 16'(MAX_WORDS)) begin
                            state      <= ERROR;
                            in_ready   <= 1'b0;
                            load_error <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: if (acc) begin
                    sum <= sum + in_data;
                    if (word_valid) begin
                        imem_we    <= 1'b1;
                        imem_wdata <= word;
                        imem_addr  <= BASE_ADDR + (ADDR_W'(wcnt) << 2);
                        wcnt       <= wcnt + 16'd1;
                        if (wcnt == nwords - 16'd1) begin
                            state    <= tail;
                            in_ready <= CHK_EN;
                        end
                    end
                end
                CHK: if (acc) begin
                    in_ready <= 1'b0;
                    // Sum of every byte including the checksum must be zero.
                    if (8'(sum + in_data) == 8'h00) begin
                        state <= DONE;
                    end else begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (clear) begin
                state      <= HDR;
                in_ready   <= 1'b1;
                cpu_reset  <= 1'b1;
                load_done  <= 1'b0;
                load_error <= 1'b0;
                imem_addr  <= BASE_ADDR;
                wcnt       <= '0;
                hcnt       <= 1'b0;
                sum        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader.
// Honours PROGRAM_LOADER_CHECKSUM_EN when defined.
module tb_program_loader;

    localparam int MAXW = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    program_loader #(
        .ADDR_W    (64),
        .BASE_ADDR (64'h0),
        .MAX_WORDS (MAXW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clock = ~clock;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    logic [63:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int          exp_wc[$];
    logic [7:0]  img[$];

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            wc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bit hs = 1'b0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 50 && !hs; k++) begin
            @(negedge clock);
            if (in_ready) hs = 1'b1;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        if (!hs) check("byte_timeout", 64'(hs), 64'd1);
    endtask

    function automatic int pick_gap(input int gm);
        if (gm == 0) return 0;
        if (gm == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic fill_random(input int n);
        img.delete();
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    endtask

    task automatic fill_directed();
        logic [7:0] d[8] = '{8'h8B, 8'h01, 8'h04, 8'hF8,
                             8'h00, 8'h00, 8'h00, 8'h14};
        img.delete();
        foreach (d[i]) img.push_back(d[i]);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [15:0] n, input int gm,
                        input bit midstart, input bit badck);
        logic [7:0]  s[$];
        logic [31:0] ew;
        bit          err;
        int          k;
        int          done_c;
        int          bad;
        int          m;
        wa.delete();
        wd.delete();
        wc.delete();
        exp_wc.delete();
        err = (n > 16'(MAXW));
        pulse_start();
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        send(n[7:0], pick_gap(gm));
        send(n[15:8], pick_gap(gm));
        if (!err) begin
            if (midstart) begin
                start = 1'b1;
                @(posedge clock);
                #1;
                start = 1'b0;
            end
            for (int i = 0; i < img.size(); i++) begin
                if (i == img.size() - 1)
                    check("cpu_reset_hold", 64'(cpu_reset), 64'd1);
                send(img[i], pick_gap(gm));
                s.push_back(img[i]);
                if (i % 4 == 3) exp_wc.push_back(cyc);
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            begin
                logic [7:0] a8 = 8'h00;
                logic [7:0] ck;
                foreach (s[j]) a8 = a8 + s[j];
                ck = ~a8 + 8'd1;
                if (badck) ck = ck ^ 8'h01;
                send(ck, pick_gap(gm));
                err = badck;
            end
`endif
        end
        k = 0;
        while (k < 20 && !(load_done || load_error)) begin
            @(negedge clock);
            k++;
        end
        done_c = cyc;
        check("settle", 64'(k < 20), 64'd1);
        if (err) begin
            check("err_flag", 64'(load_error), 64'd1);
            check("err_done", 64'(load_done), 64'd0);
            check("err_cpu_reset", 64'(cpu_reset), 64'd1);
            check("err_ready", 64'(in_ready), 64'd0);
            check("err_writes", 64'(wa.size()), 64'd0);
        end else begin
            check("done_flag", 64'(load_done), 64'd1);
            check("done_err", 64'(load_error), 64'd0);
            check("done_cpu_reset", 64'(cpu_reset), 64'd0);
            check("done_ready", 64'(in_ready), 64'd0);
            check("n_writes", 64'(wa.size()), 64'(n));
            m = (wa.size() < int'(n)) ? wa.size() : int'(n);
            bad = 0;
            for (int i = 0; i < m; i++) begin
                ew = {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
                if (i < 4) begin
                    check("waddr", wa[i], 64'(4 * i));
                    check("wdata", 64'(wd[i]), 64'(ew));
                    check("we_latency", 64'(wc[i]), 64'(exp_wc[i]));
                end else if (wa[i] !== 64'(4 * i) || wd[i] !== ew ||
                             wc[i] != exp_wc[i]) begin
                    bad++;
                end
            end
            if (m > 4) check("bulk_writes", 64'(bad), 64'd0);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
            if (m > 0 && m == int'(n))
                check("done_latency", 64'(done_c), 64'(wc[m-1] + 1));
`endif
        end
    endtask

    initial begin
        #12;
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_addr", imem_addr, 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_error", 64'(load_error), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (15) begin
            @(posedge clock);
            #1;
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("idle_ready", 64'(in_ready), 64'd0);
        check("idle_cpu_reset", 64'(cpu_reset), 64'd1);
        check("idle_writes", 64'(wa.size()), 64'd0);

        fill_directed();
        load(16'd2, 0, 1'b0, 1'b0);
        load(16'd2, 1, 1'b0, 1'b0);

        img.delete();
        load(16'd1025, 0, 1'b0, 1'b0);
        fill_random(3);
        load(16'd3, 2, 1'b0, 1'b0);

        wa.delete();
        pulse_start();
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h8B, 0);
        send(8'h01, 0);
        #2;
        reset = 1'b0;
        #1;
        check("abort_cpu_reset", 64'(cpu_reset), 64'd1);
        check("abort_ready", 64'(in_ready), 64'd0);
        check("abort_we", 64'(imem_we), 64'd0);
        check("abort_addr", imem_addr, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("abort_writes", 64'(wa.size()), 64'd0);
        fill_directed();
        load(16'd2, 2, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            int n = int'($urandom_range(0, 5));
            fill_random(n);
            load(16'(n), 2, t == 2, 1'b0);
        end

        fill_random(MAXW);
        load(16'(MAXW), 0, 1'b0, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        fill_directed();
        load(16'd2, 0, 1'b0, 1'b1);
        fill_directed();
        load(16'd2, 0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
